// File: rtl/limber_gnrl_eth_fcs_tx.sv
// limber_gnrl_eth_fcs_tx: passes frame content through and appends the 4-byte
// IEEE 802.3 FCS, then holds off new frames for a programmable inter-frame gap.
// Optional minimum-size zero padding is compiled in with LIMBER_FCS_PAD_EN.
module limber_gnrl_eth_fcs_tx #(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned MIN_FRAME  = 60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_last,
  input  logic        i_ready,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt
);

  localparam int unsigned IFG_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int unsigned IFG_LAST = (IFG_CYCLES > 0) ? (IFG_CYCLES - 1) : 0;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

`ifdef LIMBER_FCS_PAD_EN
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAD, S_FCS, S_IFG} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_FCS, S_IFG} state_t;
`endif

  state_t             state, state_nxt;
  logic [31:0]        crc;
  logic [15:0]        byte_cnt;
  logic [15:0]        cnt_inc;
  logic [2:0]         fcs_idx;
  logic [IFG_W-1:0]   ifg_cnt;
  logic [31:0]        fcs_word;
  logic [7:0]         fcs_byte;
  logic               out_adv;
  logic               in_acc;
  logic               load_in, load_pad, load_fcs, drain, fcs_done;

  // Reflected CRC-32 (poly 0x04C11DB7) folded one byte at a time, LSB first
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign out_adv  = ~o_valid | i_ready;
  assign o_ready  = ~i_rst & ((state == S_IDLE) | (state == S_DATA)) & out_adv;
  assign in_acc   = i_valid & o_ready;
  assign cnt_inc  = (byte_cnt == 16'hFFFF) ? byte_cnt : (byte_cnt + 16'd1);
  assign fcs_word = ~crc;
  assign fcs_byte = 8'(fcs_word >> {fcs_idx[1:0], 3'b000});
  assign o_busy   = (state != S_IDLE);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    load_in   = 1'b0;
    load_pad  = 1'b0;
    load_fcs  = 1'b0;
    drain     = 1'b0;
    fcs_done  = 1'b0;
    case (state)
      S_IDLE, S_DATA: begin
        if (in_acc) begin
          load_in = 1'b1;
          if (i_last) begin
`ifdef LIMBER_FCS_PAD_EN
            state_nxt = (cnt_inc < 16'(MIN_FRAME)) ? S_PAD : S_FCS;
`else
            state_nxt = S_FCS;
`endif
          end else begin
            state_nxt = S_DATA;
          end
        end else if (out_adv) begin
          drain = 1'b1;
        end
      end
`ifdef LIMBER_FCS_PAD_EN
      S_PAD: begin
        if (out_adv) begin
          load_pad = 1'b1;
          if (cnt_inc == 16'(MIN_FRAME)) state_nxt = S_FCS;
        end
      end
`endif
      S_FCS: begin
        if (fcs_idx != 3'd4) begin
          load_fcs = out_adv;
        end else if (i_ready) begin
          fcs_done  = 1'b1;
          state_nxt = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;
        end
      end
      S_IFG: begin
        if (ifg_cnt == IFG_W'(IFG_LAST)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output register, CRC accumulator and counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      crc         <= CRC_INIT;
      byte_cnt    <= 16'd0;
      fcs_idx     <= 3'd0;
      ifg_cnt     <= '0;
      o_frame_cnt <= 16'd0;
    end else begin
      if (load_in) begin
        o_data   <= i_data;
        o_valid  <= 1'b1;
        o_last   <= 1'b0;
        crc      <= crc32_byte(crc, i_data);
        byte_cnt <= cnt_inc;
      end else if (load_pad) begin
        o_data   <= 8'h00;
        o_valid  <= 1'b1;
        o_last   <= 1'b0;
        crc      <= crc32_byte(crc, 8'h00);
        byte_cnt <= cnt_inc;
      end else if (load_fcs) begin
        o_data   <= fcs_byte;
        o_valid  <= 1'b1;
        o_last   <= (fcs_idx == 3'd3);
        fcs_idx  <= fcs_idx + 3'd1;
      end else if (drain || fcs_done) begin
        o_valid  <= 1'b0;
        o_last   <= 1'b0;
      end
      // Frame complete: count it and re-arm the CRC for the next frame
      if (fcs_done) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
        crc         <= CRC_INIT;
        byte_cnt    <= 16'd0;
        fcs_idx     <= 3'd0;
      end
      if (state == S_IFG) begin
        ifg_cnt <= (ifg_cnt == IFG_W'(IFG_LAST)) ? '0 : (ifg_cnt + IFG_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_limber_gnrl_eth_fcs_tx.sv
// Directed bench for limber_gnrl_eth_fcs_tx: known CRC vectors, stalls,
// inter-frame gap length and mid-frame reset.
module tb_limber_gnrl_eth_fcs_tx;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        i_last;
  logic        o_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_last;
  logic        i_ready;
  logic        o_busy;
  logic [15:0] o_frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] ref_q[$];
  logic [7:0] exp_q[$];
  int         last_pos, first_cyc, last_cyc;

  limber_gnrl_eth_fcs_tx dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_last      (o_last),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_frame_cnt (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference FCS: MSB-first shift register over LSB-first wire bits, result bit-reversed
  function automatic logic [31:0] fcs_model(input logic [7:0] b[$]);
    logic [31:0] c;
    logic [31:0] r;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (b[n]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[31] ^ b[n][k];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C1_1DB7;
      end
    end
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return ~r;
  endfunction

  // Expected wire image: content, optional zero pad up to min_len, then FCS LSB first
  task automatic build_exp(input int min_len);
    logic [31:0] f;
    exp_q = tx_q;
    while (exp_q.size() < min_len) exp_q.push_back(8'h00);
    f = fcs_model(exp_q);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(f >> (8 * k)));
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    check({tag, "_last_pos"}, 32'(last_pos), 32'(exp_q.size()));
    for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++)
      check($sformatf("%s_byte%0d", tag, k), 32'(rx_q[k]), 32'(exp_q[k]));
  endtask

  // Drive tx_q from start_idx and collect output until o_last handshakes
  task automatic run_frame(input bit stall, input int start_idx);
    int         idx;
    int         cyc;
    bit         done;
    bit         held;
    logic [9:0] held_val;
    idx = start_idx; cyc = 0; done = 0; held = 0; held_val = '0;
    rx_q.delete(); last_pos = 0; first_cyc = -1; last_cyc = -1;
    while (!done && cyc < 4000) begin
      @(negedge i_clk);
      i_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < tx_q.size()) begin
        i_valid = 1'b1;
        i_data  = tx_q[idx];
        i_last  = (idx == tx_q.size() - 1);
      end else begin
        i_valid = 1'b0;
        i_data  = 8'h00;
        i_last  = 1'b0;
      end
      #4;
      if (held) check("stall_hold", 32'({o_valid, o_last, o_data}), 32'(held_val));
      held     = o_valid & ~i_ready;
      held_val = {o_valid, o_last, o_data};
      if (i_valid && o_ready) idx++;
      if (o_valid && i_ready) begin
        rx_q.push_back(o_data);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (o_last) begin
          last_pos = rx_q.size();
          done     = 1'b1;
        end
      end
      cyc++;
    end
    if (!done) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge i_clk);
      i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
      #4;
      if (o_ready && !o_busy) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_o_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_o_data"}, 32'(o_data), 32'd0);
    check({tag, "_o_last"}, 32'(o_last), 32'd0);
    check({tag, "_o_ready"}, 32'(o_ready), 32'd0);
    check({tag, "_o_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_frame_cnt"}, 32'(o_frame_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] known[13];
    int         low;
    int         vio;
    bit         up;
    known = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};

    i_rst = 1'b1; i_data = 8'h00; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    #4;
    check_reset_values("reset");
    @(negedge i_clk);
    i_rst = 1'b0;

    // "123456789" with i_ready high: known FCS 26 39 F4 CB, 13 back-to-back bytes
    tx_q.delete();
    for (int k = 0; k < 9; k++) tx_q.push_back(8'(8'h31 + k));
    exp_q.delete();
    foreach (known[k]) exp_q.push_back(known[k]);
    run_frame(1'b0, 0);
    compare_frame("crc_check");
    check("crc_check_span", 32'(last_cyc - first_cyc), 32'd12);

    // Offer the next frame immediately; o_ready must stay low for the full gap
    ref_q.delete();
    for (int k = 0; k < 100; k++) ref_q.push_back(8'((k * 7 + 3) & 8'hFF));
    tx_q = ref_q;
    low = 0; vio = 0; up = 1'b0;
    for (int k = 0; k < 100 && !up; k++) begin
      @(negedge i_clk);
      i_ready = 1'b1; i_valid = 1'b1; i_data = tx_q[0]; i_last = 1'b0;
      #4;
      if (o_ready) up = 1'b1;
      else begin
        low++;
        if (o_valid) vio++;
      end
    end
    check("ifg_ready_low_cycles", 32'(low), 32'd12);
    check("ifg_valid_seen", 32'(vio), 32'd0);
    check("frame_cnt_1", 32'(o_frame_cnt), 32'd1);
    run_frame(1'b0, 1);
    build_exp(0);
    compare_frame("b2b_100");
    ref_q = rx_q;

    // Same 100-byte frame under random backpressure must produce the same bytes
    wait_idle();
    check("frame_cnt_2", 32'(o_frame_cnt), 32'd2);
    run_frame(1'b1, 0);
    exp_q = ref_q;
    compare_frame("stall_100");

`ifdef LIMBER_FCS_PAD_EN
    // Single byte padded to 60 bytes of content
    wait_idle();
    tx_q.delete(); tx_q.push_back(8'hAA);
    run_frame(1'b0, 0);
    build_exp(60);
    check("pad_1_explen", 32'(exp_q.size()), 32'd64);
    compare_frame("pad_1");
    // Exactly minimum length: no pad bytes inserted
    wait_idle();
    tx_q.delete();
    for (int k = 0; k < 60; k++) tx_q.push_back(8'(k + 1));
    run_frame(1'b0, 0);
    build_exp(0);
    compare_frame("pad_60");
`else
    // Single byte frame carrying i_last on the first beat: FCS follows directly
    wait_idle();
    tx_q.delete(); tx_q.push_back(8'hAA);
    run_frame(1'b0, 0);
    build_exp(0);
    compare_frame("short_1");
`endif

    // Reset mid-payload drops the frame and clears every output
    wait_idle();
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      i_ready = 1'b1; i_valid = 1'b1; i_data = 8'(8'h50 + k); i_last = 1'b0;
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rst   = 1'b1;
    #4;
    check_reset_values("mid_reset");
    @(negedge i_clk);
    i_rst = 1'b0;
    tx_q.delete();
    for (int k = 0; k < 9; k++) tx_q.push_back(8'(8'h31 + k));
    exp_q.delete();
    foreach (known[k]) exp_q.push_back(known[k]);
    run_frame(1'b0, 0);
    compare_frame("post_reset");
    @(negedge i_clk);
    #4;
    check("post_reset_frame_cnt", 32'(o_frame_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
